// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the memory fill responder.
// Imported by the top and the latency pipe.
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    WRITE
  } state_t;

  localparam logic DST_I = 1'b0;
  localparam logic DST_D = 1'b1;

  localparam int BLOCK_BYTES = 16;
  localparam int OFF_MASK    = BLOCK_BYTES - 1;

  function automatic int off_mask(input int words);
    return 2 * words - 1;
  endfunction

endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-depth delay line for fill words.
// Only the valid bits are reset; payload is zeroed at the output when invalid.
module mem_latency_pipe
  import mem_fill_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_dst,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_dst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] lst;
  logic [LATENCY-1:0] dsq;
  logic [ADDR_W-1:0]  adr [LATENCY];
  logic [DATA_W-1:0]  dat [LATENCY];

  // Valid bits shift with async clear so a reset kills in-flight words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
    end
  end

  // Payload shifts alongside the valid bits without reset
  always_ff @(posedge clk) begin
    lst[0] <= in_last;
    dsq[0] <= in_dst;
    adr[0] <= in_addr;
    dat[0] <= in_data;
    for (int i = 1; i < LATENCY; i++) begin
      lst[i] <= lst[i-1];
      dsq[i] <= dsq[i-1];
      adr[i] <= adr[i-1];
      dat[i] <= dat[i-1];
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_last  = vld[LATENCY-1] & lst[LATENCY-1];
  assign out_dst   = vld[LATENCY-1] & dsq[LATENCY-1];
  assign out_addr  = vld[LATENCY-1] ? adr[LATENCY-1] : '0;
  assign out_data  = vld[LATENCY-1] ? dat[LATENCY-1] : '0;

endmodule

// File: rtl/mem_fill_responder.sv
// Memory-side responder: arbitrates I/D cache requests, streams block
// fills through a fixed-latency pipe and commits single-word writes.
module mem_fill_responder
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = BLOCK_BYTES / 2,
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_dst,
  output logic              rsp_last,
  output logic              wr_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] OFF = ADDR_W'(off_mask(BLOCK_WORDS));
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CMAX  = BLOCK_WORDS > LATENCY ? BLOCK_WORDS : LATENCY;
  localparam int CNT_W = $clog2(CMAX) + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_LAT  = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              dst_q;
  logic [DATA_W-1:0] wdata_q;
  logic              take_d, take_i;
  logic              issue, issue_last, commit;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a[ADDR_W-1:1]) % 32'(DEPTH_WORDS));
  endfunction

  // D side wins ties; nothing is granted outside IDLE or during reset
  assign take_d  = (state_q == IDLE) && !rst && d_req;
  assign take_i  = (state_q == IDLE) && !rst && i_req && !d_req;
  assign d_grant = take_d;
  assign i_grant = take_i;
  assign busy    = (state_q != IDLE);
  assign wr_done = commit;

  assign issue_addr = addr_q + (ADDR_W'(cnt_q) << 1);
  assign issue_data = mem[word_idx(issue_addr)];

  // Next-state, word counter and per-state strobes
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (take_d)      state_d = d_we ? WRITE : FILL;
        else if (take_i) state_d = FILL;
      end
      FILL: begin
        issue      = 1'b1;
        issue_last = (cnt_q == LAST_WORD);
        cnt_d      = cnt_q + 1'b1;
        if (issue_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_LAT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WRITE: begin
        cnt_d  = cnt_q + 1'b1;
        commit = (cnt_q == LAST_LAT);
        if (commit) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and captured request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dst_q   <= DST_I;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_d) begin
        addr_q  <= d_we ? d_addr : (d_addr & ~OFF);
        dst_q   <= DST_D;
        wdata_q <= d_wdata;
      end else if (take_i) begin
        addr_q <= i_addr & ~OFF;
        dst_q  <= DST_I;
      end
    end
  end

  // Array write lands on the edge closing the last write cycle
  always_ff @(posedge clk) begin
    if (commit) mem[word_idx(addr_q)] <= wdata_q;
  end

  mem_latency_pipe #(
    .LATENCY (LATENCY),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_last   (issue_last),
    .in_dst    (dst_q),
    .in_addr   (issue_addr),
    .in_data   (issue_data),
    .out_valid (rsp_valid),
    .out_last  (rsp_last),
    .out_dst   (rsp_dst),
    .out_addr  (rsp_addr),
    .out_data  (rsp_data)
  );

endmodule
